dat_serializer: RTL
===================

# dat_serializer

Parallel-to-serial shifter for the SD host DAT path, transmit direction. It accepts a parallel word and a frame length through a single-cycle load handshake and drives the word onto a one-bit serial line, LSB first, one bit per enabled clock. It signals the end of the frame with a one-cycle `complete` pulse. It pairs bit-for-bit with the DAT-line deserializer, so the two can be connected in loopback.

## Interface
- `BITS`, 32: width of the parallel data word.
- `BITS_COUNTER`, 8: width of the frame-length and bit counters; must be at least clog2(BITS+1).

- `clk`  in  1  Serial bit clock; all state updates on its rising edge.
- `reset`  in  1  Asynchronous, active-high.
- `enable`  in  1  Shift qualifier; low suspends shifting.
- `load`  in  1  Frame request; sampled at each rising edge.
- `framesize`  in  BITS_COUNTER  Number of bits to send; captured on load.
- `in`  in  BITS  Parallel data; captured on load.
- `out`  out  1  Serial data; idles high.
- `busy`  out  1  Frame in progress; load is ignored while high.
- `complete`  out  1  One-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (asynchronous) forces:
  - state = IDLE, `out` = 1, `busy` = 0, `complete` = 0.
  - Shift register = 0, bit counter = 0, length register = 0.
- IDLE: `out` = 1.
  - If `load` = 1 and 1 ≤ `framesize` ≤ BITS: capture `in` into the shift register and `framesize` into the length register, clear the counter, go to SHIFT.
  - Any other `load`: ignored, no flag raised.
  - `load` is accepted regardless of `enable`.
- SHIFT, on each edge with `enable` = 1:
  - `out` ← shreg[0], shreg ← shreg >> 1, counter ← counter + 1.
  - When counter = length at an edge with `enable` = 1, go to DONE.
- SHIFT, `enable` = 0: `out`, shreg and counter all hold.
- SHIFT ignores `load`, `in` and `framesize` entirely.
- DONE lasts exactly one cycle: `complete` = 1, `out` = 1, `busy` = 0.
  - A valid `load` here is accepted as in IDLE, giving back-to-back frames; otherwise go to IDLE.
- Bits above `framesize` in `in` are never transmitted.
- Reset mid-frame aborts the frame: no `complete` pulse, and `out` returns high immediately.

## Timing
- Load accepted at edge N, `enable` held high:
  - `out` = in[k-1] during cycle N+k, for k = 1..framesize.
  - `busy` = 1 during cycles N+1..N+framesize.
  - `complete` = 1 and `out` = 1 during cycle N+framesize+1.
- Each enabled bit is held for exactly one cycle.
- Each cycle with `enable` = 0 during SHIFT stretches the current bit by one cycle and delays `complete` by one cycle.
- `enable` has no effect in IDLE or DONE.
- Load accepted in DONE at edge M: the first bit appears in cycle M+1, with no idle-high gap between frames.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `dat_pkg` holds:
  - the DAT idle level constant (1'b1),
  - the serializer state enum (IDLE/SHIFT/DONE),
  - the default BITS / BITS_COUNTER values shared with the deserializer.
- No sub-module: the counter and shift register are inline; a single always block for state and one for outputs is sufficient.

## Test plan
- Reset → `out` = 1, `busy` = 0, `complete` = 0. No `complete` pulse with `load` held low for 20 cycles.
- `in` = 0x000000A5, `framesize` = 8, `enable` = 1:
  - `out` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8.
  - `complete` high only in cycle N+9.
  - `busy` high in cycles N+1..N+8.
- Same frame with `enable` low for 3 cycles after bit 2 → bit 2 held 4 cycles; `complete` in cycle N+12.
- Rejected loads:
  - `load` with `in` = 0xFFFFFFFF during SHIFT → ignored; the original frame completes unchanged.
  - `framesize` = 0 or 33 in IDLE → ignored; `busy` stays 0.
- Reset asserted mid-bit 5 of an 8-bit frame → `out` = 1 and `busy` = 0 with no edge needed; no `complete` pulse. A following 4-bit load of 0x3 sends 1,1,0,0.
- Back-to-back frames:
  - `framesize` = 32, `in` = 0x80000001 → bit 1 and bit 32 are 1, bits 2..31 are 0.
  - Second load issued in the DONE cycle starts its bit 1 in the following cycle.
  - Loopback through the deserializer recovers both words.

Source files
------------

// File: rtl/dat_pkg.sv
// Shared definitions for the SD host DAT-line serializer and deserializer.
package dat_pkg;

  localparam logic DAT_IDLE_LEVEL = 1'b1;

  localparam int DAT_BITS         = 32;
  localparam int DAT_BITS_COUNTER = 8;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_DONE
  } ser_state_t;

endpackage

// File: rtl/dat_serializer.sv
// Parallel-to-serial shifter for the SD host DAT transmit path.
// Sends a captured word LSB first and ends each frame with a one-cycle complete pulse.
module dat_serializer
  import dat_pkg::*;
#(
  parameter int BITS         = DAT_BITS,
  parameter int BITS_COUNTER = DAT_BITS_COUNTER
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [BITS_COUNTER-1:0] framesize,
  input  logic [BITS-1:0]         in,
  output logic                    out,
  output logic                    busy,
  output logic                    complete
);

  ser_state_t state, stateNext;

  logic [BITS-1:0]         shreg;
  logic [BITS_COUNTER-1:0] count;
  logic [BITS_COUNTER-1:0] length;
  logic                    sizeOk;
  logic                    accept;
  logic                    lastBit;

  // A load is honoured only outside SHIFT and only for 1..BITS bits.
  always_comb begin
    sizeOk    = (framesize != '0) && (framesize <= BITS_COUNTER'(BITS));
    accept    = load && sizeOk && (state != SER_SHIFT);
    lastBit   = (state == SER_SHIFT) && enable && (count == length);
    stateNext = state;
    case (state)
      SER_IDLE:  if (accept) stateNext = SER_SHIFT;
      SER_SHIFT: if (lastBit) stateNext = SER_DONE;
      SER_DONE:  stateNext = accept ? SER_SHIFT : SER_IDLE;
      default:   stateNext = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SER_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // The first bit is driven on the accepting edge itself, so count starts at 1
  // and the frame ends on the enabled edge where count has reached length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out      <= DAT_IDLE_LEVEL;
      busy     <= 1'b0;
      complete <= 1'b0;
      shreg    <= '0;
      count    <= '0;
      length   <= '0;
    end else begin
      complete <= lastBit;
      if (accept) begin
        out    <= in[0];
        shreg  <= in >> 1;
        length <= framesize;
        count  <= BITS_COUNTER'(1);
        busy   <= 1'b1;
      end else if (lastBit) begin
        out  <= DAT_IDLE_LEVEL;
        busy <= 1'b0;
      end else if ((state == SER_SHIFT) && enable) begin
        out   <= shreg[0];
        shreg <= shreg >> 1;
        count <= count + BITS_COUNTER'(1);
      end else if (state != SER_SHIFT) begin
        out  <= DAT_IDLE_LEVEL;
        busy <= 1'b0;
      end
    end
  end

endmodule
